// File: rtl/pulse_stretcher.sv
// pulse_stretcher: stretches request pulses to WIDTH-cycle outputs spaced by GAP low cycles; PULSE_STRETCHER_DROP_CNT_EN adds drop_cnt
module pulse_stretcher #(
  parameter int WIDTH  = 4,
  parameter int GAP    = 1,
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              din,
  output logic              dout,
  output logic              busy,
  output logic [PEND_W-1:0] pending
`ifdef PULSE_STRETCHER_DROP_CNT_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);
  localparam int MAXV = WIDTH > GAP ? WIDTH : GAP;
  localparam int CW = MAXV > 1 ? $clog2(MAXV) : 1;
  localparam logic [CW-1:0] W_INIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] G_INIT = CW'(GAP > 0 ? GAP - 1 : 0);
  localparam logic [PEND_W-1:0] P_MAX = '1;
  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_GAP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [PEND_W-1:0] pend_n;
  logic inc;
  assign busy = state != S_IDLE;
  // next state: count down each interval; the final cycle consumes a request (din first-hand or pending) to restart
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pend_n  = pending;
    inc     = 1'b0;
    if (state == S_IDLE) begin
      if (din) begin
        state_n = S_HIGH;
        cnt_n   = W_INIT;
      end
    end else if (cnt != '0) begin
      cnt_n = cnt - CW'(1);
      inc   = din;
    end else if (state == S_HIGH && GAP > 0) begin
      state_n = S_GAP;
      cnt_n   = G_INIT;
      inc     = din;
    end else if (pending != '0 || din) begin
      state_n = S_HIGH;
      cnt_n   = W_INIT;
      pend_n  = pending + PEND_W'(din) - PEND_W'(1);
    end else begin
      state_n = S_IDLE;
    end
    if (inc && pending != P_MAX) pend_n = pending + PEND_W'(1);
  end
  // state, interval counter, pending count and registered output
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      pending <= '0;
      dout    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pending <= pend_n;
      dout    <= state_n == S_HIGH;
    end
  end
`ifdef PULSE_STRETCHER_DROP_CNT_EN
  // a request arriving with the queue full is lost; count it, saturating at 255
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) drop_cnt <= '0;
    else if (inc && pending == P_MAX && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
  end
`endif
endmodule
